vote_machine_n: RTL and testbench
=================================

# vote_machine_n

Parametrised N-candidate voting machine: the next generation of the four-button machine. It debounces each candidate button into exactly one vote per press and rejects ballots where several buttons qualify in the same cycle. It keeps a saturating tally per candidate, shows an acknowledge pattern on the LEDs, and in result mode displays the tally of whichever candidate's button is pressed. It sits directly between the board buttons/mode switch and the LED bank.

## Interface
- NUM_CAND, 4: number of candidates/buttons; legal 2..16.
- CNT_W, 8: tally width and LED width.
- DEBOUNCE_CYC, 10: consecutive high samples required before a press qualifies; legal 1..2^16-1.
- ACK_CYC, 10: cycles the LEDs show all-ones after an accepted vote; legal 1..2^16-1.
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- mode  in  1  0 = voting, 1 = result; synchronous, sampled every edge.
- button  in  NUM_CAND  raw candidate buttons, active-high, already synchronised.
- led  out  CNT_W  LED bank.
- vote_accept  out  1  one-cycle pulse when a tally is incremented.
- vote_reject  out  1  one-cycle pulse when a qualified ballot is discarded.
- winner  out  clog2(NUM_CAND)  index of leading candidate (see Configuration).
- winner_valid  out  1  winner meaningful (see Configuration).
- tie  out  1  two or more candidates share the maximum (see Configuration).

## Operation
- Debounce, per button i: the counter clears while button[i]=0. While high it increments and saturates at DEBOUNCE_CYC. press[i] pulses for exactly one cycle, on the cycle the counter reaches DEBOUNCE_CYC. Holding the button produces no further pulses; it must be released (at least one low sample) to re-arm.
- Ballot qualification: a ballot qualifies when one or more press[] pulses occur in the same cycle.
- FSM states:
  - IDLE (reset state). Mode=0. Exactly one press pulse: tally[i]+1, vote_accept, go to ACK. Two or more press pulses: vote_reject, no tally change, stay in IDLE. mode=1: go to RESULT.
  - ACK. Mode=0. A down-counter loads ACK_CYC and returns to IDLE on expiry. Press pulses during ACK are ignored: no tally change, no reject. mode=1 aborts ACK and goes to RESULT.
  - RESULT. Press pulses never change tallies. Exactly one press pulse latches sel=i. Multiple pulses leave sel unchanged. mode=0: go to IDLE and clear sel-valid.
- Tallies are CNT_W bits and saturate at 2^CNT_W-1. An accept at saturation still pulses vote_accept but leaves the value unchanged.
- LED source:
  - ACK: all ones.
  - IDLE: zero.
  - RESULT: tally[sel] once a selection exists, else zero. The display tracks the live tally register.
- vote_accept and vote_reject are mutually exclusive and never assert outside IDLE.

## Timing
- Reset asserted (asynchronous, any time, including mid-ACK or mid-debounce): led=0, vote_accept=0, vote_reject=0, winner=0, winner_valid=0, tie=0, all tallies 0, all debounce counters 0, FSM=IDLE, sel invalid. Release is synchronous to the next posedge.
- Press latency: with button[i] rising before edge E1 and held, press[i] is internal-high in the cycle after edge E_DEBOUNCE_CYC.
- Vote/reject latency: tally, vote_accept/vote_reject and the state change all register on the next edge. led=all-ones is visible one cycle after that press cycle.
- ACK duration: led all-ones for exactly ACK_CYC cycles, then zero.
- Mode switch: the FSM changes on the edge after mode changes. In RESULT, led updates one edge after the selecting press pulse.
- Winner outputs are registered: one cycle behind tallies.

## Configuration
- VOTE_WINNER_EN defined: winner = index of the maximum tally (lowest index on equal values). winner_valid=1 when the maximum is nonzero. tie=1 when at least two candidates equal the nonzero maximum. The comparison is a registered linear scan over all candidates, updated every cycle.
- VOTE_WINNER_EN undefined: winner, winner_valid and tie are tied to 0, and no comparator logic is built. All other behaviour is identical.

## Test plan
- Default params; button[2] high 10 cycles, then low → one vote_accept, tally[2]=1, led=0xFF for 10 cycles then 0x00; holding button[2] for 50 cycles still yields tally[2]=1.
- button[0] and button[3] rise on the same edge, held 12 cycles → one vote_reject, all tallies 0, led stays 0x00.
- button[1] pressed 9 cycles, released, pressed 10 → exactly one accept; a second full press during ACK is ignored (tally[1]=1, no reject).
- 300 valid presses of button[0] with CNT_W=8 → tally[0]=255, 300 vote_accept pulses; mode=1, press button[0] → led=0xFF; press button[3] → led=0x00.
- reset driven low mid-ACK with tallies {3,1,0,0} → all outputs 0 immediately, tallies 0, FSM IDLE after release.
- VOTE_WINNER_EN defined, tallies {2,5,5,0} → winner=1, tie=1, winner_valid=1; one more vote for cand 2 → winner=2, tie=0.

Source files
------------

// File: rtl/vote_machine_n.sv
// N-candidate voting machine: debounced buttons, saturating tallies, ACK/RESULT LED display; winner scan under VOTE_WINNER_EN.
// Latency: press is internal one cycle after DEBOUNCE_CYC high samples; accept/reject/tally register on the next edge; winner lags tallies by one cycle.
// Backpressure: none; presses during ACK, and ballots with several simultaneous presses, are discarded rather than queued.
module vote_machine_n #(
    parameter int NUM_CAND     = 4,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CYC = 10,
    parameter int ACK_CYC      = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mode,
    input  logic [NUM_CAND-1:0]         button,
    output logic [CNT_W-1:0]            led,
    output logic                        vote_accept,
    output logic                        vote_reject,
    output logic [$clog2(NUM_CAND)-1:0] winner,
    output logic                        winner_valid,
    output logic                        tie
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam logic [15:0] DB_MAX   = 16'(DEBOUNCE_CYC);
    localparam logic [15:0] ACK_LOAD = 16'(ACK_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_RESULT} state_t;

    state_t               state, state_nxt;
    logic [15:0]          ack_cnt, ack_nxt;
    logic [15:0]          db_cnt [NUM_CAND];
    logic [NUM_CAND-1:0]  press;
    logic [CNT_W-1:0]     tally [NUM_CAND];
    logic [IDX_W-1:0]     sel, sel_nxt, press_idx;
    logic                 sel_vld, sel_vld_nxt;
    logic                 acc_nxt, rej_nxt, inc;
    logic                 press_any, press_one;

    // Counter saturates at DB_MAX, so the pulse fires once per high run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) db_cnt[i] <= '0;
            press <= '0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (!button[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] != DB_MAX)
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                press[i] <= button[i] && (db_cnt[i] == DB_MAX - 16'd1);
            end
        end
    end

    assign press_any = |press;
    assign press_one = press_any && ((press & (press - NUM_CAND'(1))) == '0);

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (press[i]) press_idx = IDX_W'(i);
    end

    always_comb begin
        state_nxt   = state;
        ack_nxt     = ack_cnt;
        sel_nxt     = sel;
        sel_vld_nxt = sel_vld;
        acc_nxt     = 1'b0;
        rej_nxt     = 1'b0;
        inc         = 1'b0;
        case (state)
            S_IDLE: begin
                if (mode) begin
                    state_nxt = S_RESULT;
                end else if (press_one) begin
                    acc_nxt   = 1'b1;
                    inc       = 1'b1;
                    state_nxt = S_ACK;
                    ack_nxt   = ACK_LOAD;
                end else if (press_any) begin
                    rej_nxt = 1'b1;
                end
            end
            S_ACK: begin
                if (mode)
                    state_nxt = S_RESULT;
                else if (ack_cnt <= 16'd1)
                    state_nxt = S_IDLE;
                else
                    ack_nxt = ack_cnt - 16'd1;
            end
            S_RESULT: begin
                if (!mode) begin
                    state_nxt   = S_IDLE;
                    sel_vld_nxt = 1'b0;
                end else if (press_one) begin
                    sel_nxt     = press_idx;
                    sel_vld_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ack_cnt     <= '0;
            sel         <= '0;
            sel_vld     <= 1'b0;
            vote_accept <= 1'b0;
            vote_reject <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
        end else begin
            state       <= state_nxt;
            ack_cnt     <= ack_nxt;
            sel         <= sel_nxt;
            sel_vld     <= sel_vld_nxt;
            vote_accept <= acc_nxt;
            vote_reject <= rej_nxt;
            for (int i = 0; i < NUM_CAND; i++)
                if (inc && press_idx == IDX_W'(i) && tally[i] != '1)
                    tally[i] <= tally[i] + CNT_W'(1);
        end
    end

    always_comb begin
        led = '0;
        case (state)
            S_ACK:    led = '1;
            S_RESULT: if (sel_vld) led = tally[sel];
            default:  led = '0;
        endcase
    end

`ifdef VOTE_WINNER_EN
    logic [CNT_W-1:0] best_val;
    logic [IDX_W-1:0] best_idx;
    logic             best_tie;

    // Strict '>' keeps the lowest index on equal values.
    always_comb begin
        best_val = tally[0];
        best_idx = '0;
        best_tie = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally[i] > best_val) begin
                best_val = tally[i];
                best_idx = IDX_W'(i);
                best_tie = 1'b0;
            end else if (tally[i] == best_val && best_val != '0) begin
                best_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            winner       <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
        end else begin
            winner       <= best_idx;
            winner_valid <= (best_val != '0);
            tie          <= best_tie;
        end
    end
`else
    assign winner       = '0;
    assign winner_valid = 1'b0;
    assign tie          = 1'b0;
`endif

endmodule

// File: tb/tb_vote_machine_n.sv
// Bench for vote_machine_n: accept/reject pulses checked against a queue of expected events, LEDs checked directly.
module tb_vote_machine_n;
    localparam int NC   = 4;
    localparam int CW   = 8;
    localparam int DEB  = 10;
    localparam int ACKC = 10;
`ifdef VOTE_WINNER_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mode  = 1'b0;
    logic [NC-1:0] button = '0;
    logic [CW-1:0] led;
    logic          vote_accept, vote_reject;
    logic [1:0]    winner;
    logic          winner_valid, tie;

    vote_machine_n #(.NUM_CAND(NC), .CNT_W(CW), .DEBOUNCE_CYC(DEB), .ACK_CYC(ACKC)) dut (
        .clock(clock), .reset(reset), .mode(mode), .button(button), .led(led),
        .vote_accept(vote_accept), .vote_reject(vote_reject),
        .winner(winner), .winner_valid(winner_valid), .tie(tie)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    logic [1:0] exp_q[$];   // 2'b10 accept, 2'b01 reject

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse on the DUT side must match the next queued expectation.
    always @(negedge clock) begin
        if (reset && (vote_accept || vote_reject)) begin
            if (vote_accept) n_acc++;
            if (exp_q.size() == 0)
                check("unexpected_pulse", {30'd0, vote_accept, vote_reject}, 32'd0);
            else
                check("pulse", {30'd0, vote_accept, vote_reject}, {30'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #600000;
        $display("FAIL timeout: bench did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1'b0; mode = 1'b0; button = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic press(input logic [NC-1:0] mask, input int hold);
        @(negedge clock);
        button = mask;
        repeat (hold) @(negedge clock);
        button = '0;
    endtask

    task automatic do_vote(input int idx);
        exp_q.push_back(2'b10);
        press(NC'(1) << idx, DEB);
        repeat (12) @(negedge clock);
    endtask

    task automatic read_tally(input int idx, input logic [CW-1:0] exp, input string name);
        mode = 1'b1;
        repeat (2) @(negedge clock);
        press(NC'(1) << idx, DEB);
        repeat (2) @(negedge clock);
        check(name, {24'd0, led}, {24'd0, exp});
    endtask

    task automatic leave_result();
        mode = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic count_led_ff(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (led == 8'hFF) n++;
        end
    endtask

    int n;
    int acc0;

    initial begin
        // Reset state while reset is held low
        repeat (2) @(negedge clock);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_pulses", {30'd0, vote_accept, vote_reject}, 32'd0);
        check("rst_winner", {29'd0, winner, winner_valid, tie}, 32'd0);
        do_reset();

        // Single vote: ACK length and tally
        exp_q.push_back(2'b10);
        press(4'b0100, DEB);
        count_led_ff(25, n);
        check("ack_len", n, ACKC);
        check("led_after_ack", {24'd0, led}, 32'd0);
        read_tally(2, 8'd1, "t1_tally2");
        leave_result();

        // Long hold yields a single vote
        do_reset();
        exp_q.push_back(2'b10);
        press(4'b0100, 50);
        repeat (12) @(negedge clock);
        read_tally(2, 8'd1, "hold_tally2");
        leave_result();

        // Simultaneous presses are rejected
        do_reset();
        exp_q.push_back(2'b01);
        press(4'b1001, 12);
        count_led_ff(20, n);
        check("reject_led_ff", n, 0);
        read_tally(0, 8'd0, "reject_tally0");
        read_tally(3, 8'd0, "reject_tally3");
        leave_result();

        // Short press ignored; overlapping press during ACK ignored
        do_reset();
        press(4'b0010, DEB - 1);
        @(negedge clock);
        exp_q.push_back(2'b10);
        button = 4'b0010;
        repeat (5) @(negedge clock);
        button = 4'b1010;
        repeat (DEB) @(negedge clock);
        button = '0;
        repeat (15) @(negedge clock);
        read_tally(1, 8'd1, "ackign_tally1");
        read_tally(3, 8'd0, "ackign_tally3");
        leave_result();

        // Saturation after 300 votes
        do_reset();
        acc0 = n_acc;
        for (int k = 0; k < 300; k++) do_vote(0);
        check("sat_accepts", n_acc - acc0, 300);
        read_tally(0, 8'hFF, "sat_tally0");
        read_tally(3, 8'h00, "sat_tally3");
        leave_result();

        // Reset mid-ACK with tallies {3,1,0,0}
        do_reset();
        do_vote(0); do_vote(0); do_vote(1);
        exp_q.push_back(2'b10);
        press(4'b0001, DEB);
        repeat (4) @(negedge clock);
        check("midack_led", {24'd0, led}, 32'hFF);
        reset = 1'b0;
        #1;
        check("arst_led", {24'd0, led}, 32'd0);
        check("arst_pulses", {30'd0, vote_accept, vote_reject}, 32'd0);
        check("arst_winner", {29'd0, winner, winner_valid, tie}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_rst_led", {24'd0, led}, 32'd0);
        read_tally(0, 8'd0, "post_rst_tally0");
        read_tally(1, 8'd0, "post_rst_tally1");
        leave_result();

        // Winner scan: {2,5,5,0} then one more vote for candidate 2
        do_reset();
        check("win_init_valid", {31'd0, winner_valid}, 32'd0);
        do_vote(0); do_vote(0);
        for (int k = 0; k < 5; k++) do_vote(1);
        for (int k = 0; k < 5; k++) do_vote(2);
        check("win_a", {29'd0, winner, winner_valid, tie}, WEN ? {29'd0, 2'd1, 1'b1, 1'b1} : 32'd0);
        do_vote(2);
        check("win_b", {29'd0, winner, winner_valid, tie}, WEN ? {29'd0, 2'd2, 1'b1, 1'b0} : 32'd0);

        repeat (5) @(negedge clock);
        check("pending_expect", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
